// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM measurement blocks.
package pwm_pkg;

  typedef enum logic {
    ARMED   = 1'b0,
    MEASURE = 1'b1
  } pwm_state_e;

  function automatic int full_scale(input int r);
    return 1 << r;
  endfunction

  function automatic int period_lo(input int r, input int tol);
    return (full_scale(r) > tol) ? full_scale(r) - tol : 0;
  endfunction

  function automatic int period_hi(input int r, input int tol);
    return full_scale(r) + tol;
  endfunction

  localparam int PWM_R_DEFAULT   = 8;
  localparam int PWM_TOL_DEFAULT = 2;
  localparam int PWM_PERIOD_LO   = period_lo(PWM_R_DEFAULT, PWM_TOL_DEFAULT);
  localparam int PWM_PERIOD_HI   = period_hi(PWM_R_DEFAULT, PWM_TOL_DEFAULT);

endpackage

// File: rtl/pwm_duty_decoder_if.sv
// Pin-side and result-side signals of the duty decoder.
interface pwm_duty_decoder_if #(
  parameter int R  = 8,
  parameter int DW = 13
);

  logic [DW-1:0] dvsr;
  logic          pwm_in;
  logic [R:0]    duty;
  logic          duty_valid;
  logic          period_err;
  logic          stuck;

  modport master (
    output dvsr, pwm_in,
    input  duty, duty_valid, period_err, stuck
  );

  modport slave (
    input  dvsr, pwm_in,
    output duty, duty_valid, period_err, stuck
  );

endinterface

// File: rtl/pwm_sync_edge.sv
// Two-flop synchronizer for an asynchronous pin plus rising-edge detect.
module pwm_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic sync,
  output logic rise
);

  logic meta;
  logic sync_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta   <= 1'b0;
      sync   <= 1'b0;
      sync_d <= 1'b0;
    end else begin
      meta   <= d;
      sync   <= meta;
      sync_d <= sync;
    end
  end

  assign rise = sync & ~sync_d;

endmodule

// File: rtl/pwm_duty_decoder.sv
// Measures duty of an incoming PWM waveform in the generator's R+1-bit format.
//   state   | meaning
//   ARMED   | waiting for a first rising edge; no previous edge to measure from
//   MEASURE | each rising edge closes a period and reports its duty
module pwm_duty_decoder
  import pwm_pkg::*;
#(
  parameter int R          = 8,
  parameter int DW         = 13,
  parameter int PERIOD_TOL = 2
) (
  input  logic clk,
  input  logic reset,
  pwm_duty_decoder_if.slave bus
);

  localparam int CW = R + 2;
  localparam logic [CW-1:0] FS    = CW'(full_scale(R));
  localparam logic [CW-1:0] P_MAX = CW'(full_scale(R + 1));
  localparam logic [CW-1:0] P_LO  = CW'(period_lo(R, PERIOD_TOL));
  localparam logic [CW-1:0] P_HI  = CW'(period_hi(R, PERIOD_TOL));

  logic          sync;
  logic          rise;
  logic [DW-1:0] tick_cnt;
  logic          tick;
  logic          timeout;

  pwm_state_e    state_q, state_d;
  logic [CW-1:0] period_cnt, period_d;
  logic [CW-1:0] high_cnt, high_d;
  logic [R:0]    duty_q, duty_d;
  logic          dv_q, dv_d;
  logic          pe_q, pe_d;
  logic          stuck_q, stuck_d;

  pwm_sync_edge u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (bus.pwm_in),
    .sync  (sync),
    .rise  (rise)
  );

  // >= keeps the prescaler bounded if dvsr is lowered mid-count
  assign tick = (tick_cnt >= bus.dvsr);

  always_ff @(posedge clk) begin
    if (reset) tick_cnt <= '0;
    else       tick_cnt <= tick ? '0 : tick_cnt + DW'(1);
  end

  assign timeout = tick && (period_cnt >= P_MAX - CW'(1));

  always_comb begin
    state_d  = state_q;
    period_d = period_cnt;
    high_d   = high_cnt;
    duty_d   = duty_q;
    dv_d     = 1'b0;
    pe_d     = 1'b0;
    stuck_d  = stuck_q;

    if (tick) begin
      if (period_cnt != P_MAX)        period_d = period_cnt + CW'(1);
      if (sync && high_cnt != P_MAX)  high_d   = high_cnt + CW'(1);
    end

    // a rising edge wins over a coincident timeout
    if (rise) begin
      period_d = tick ? CW'(1) : '0;
      high_d   = tick ? CW'(1) : '0;
      if (state_q == ARMED) begin
        state_d = MEASURE;
      end else begin
        if (period_cnt < P_LO || period_cnt > P_HI) begin
          pe_d = 1'b1;
        end else begin
          duty_d = (high_cnt > FS) ? FS[R:0] : high_cnt[R:0];
          dv_d   = 1'b1;
        end
        stuck_d = 1'b0;
      end
    end else if (timeout) begin
      duty_d   = sync ? FS[R:0] : '0;
      dv_d     = 1'b1;
      stuck_d  = 1'b1;
      period_d = '0;
      high_d   = '0;
      state_d  = ARMED;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ARMED;
      period_cnt <= '0;
      high_cnt   <= '0;
      duty_q     <= '0;
      dv_q       <= 1'b0;
      pe_q       <= 1'b0;
      stuck_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      period_cnt <= period_d;
      high_cnt   <= high_d;
      duty_q     <= duty_d;
      dv_q       <= dv_d;
      pe_q       <= pe_d;
      stuck_q    <= stuck_d;
    end
  end

  assign bus.duty       = duty_q;
  assign bus.duty_valid = dv_q;
  assign bus.period_err = pe_q;
  assign bus.stuck      = stuck_q;

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// Scoreboard bench for pwm_duty_decoder: R=8, dvsr=3 (4 clocks per tick).
module tb_pwm_duty_decoder;

  localparam int R      = 8;
  localparam int DW     = 13;
  localparam int CPT    = 4;
  localparam int K_NONE = 0;
  localparam int K_DV   = 1;
  localparam int K_PE   = 2;

  typedef struct {
    int kind;
    int duty;
    int stuck;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  pwm_duty_decoder_if #(.R(R), .DW(DW)) bus ();

  pwm_duty_decoder #(.R(R), .DW(DW), .PERIOD_TOL(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input int kind, input int duty, input int stuck);
    exp_t e;
    if (kind != K_NONE) begin
      e.kind  = kind;
      e.duty  = duty;
      e.stuck = stuck;
      sb.push_back(e);
    end
  endtask

  // One PWM period: the expectation describes what its opening rising edge reports,
  // followed by any stuck-timeouts expected before the period ends.
  task automatic run_period(input int high, input int period, input int kind,
                            input int ed, input int es, input int n_to,
                            input int to_duty, input int rst_tick);
    push_exp(kind, ed, es);
    for (int k = 0; k < n_to; k++) push_exp(K_DV, to_duty, 1);
    for (int i = 0; i < period * CPT; i++) begin
      bus.pwm_in = (i < high * CPT);
      reset = (rst_tick >= 0) && (i == rst_tick * CPT);
      @(posedge clk);
      #1;
      if (reset) begin
        chk("rst_mid_duty", int'(bus.duty), 0);
        chk("rst_mid_valid", int'(bus.duty_valid), 0);
        chk("rst_mid_perr", int'(bus.period_err), 0);
        chk("rst_mid_stuck", int'(bus.stuck), 0);
      end
    end
    reset = 1'b0;
  endtask

  task automatic hold(input logic level, input int ticks, input int n_to, input int to_duty);
    for (int k = 0; k < n_to; k++) push_exp(K_DV, to_duty, 1);
    bus.pwm_in = level;
    repeat (ticks * CPT) @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.duty_valid || bus.period_err) begin
        chk("exclusive_pulse", int'(bus.duty_valid & bus.period_err), 0);
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_report: got dv=%0b pe=%0b duty=%0d, expected no report (t=%0t)",
                   bus.duty_valid, bus.period_err, bus.duty, $time);
        end else begin
          e = sb.pop_front();
          chk("report_kind", bus.duty_valid ? K_DV : K_PE, e.kind);
          chk("report_duty", int'(bus.duty), e.duty);
          chk("report_stuck", int'(bus.stuck), e.stuck);
        end
      end
    end
  end

  initial begin : stimulus
    bus.dvsr   = 13'd3;
    bus.pwm_in = 1'b0;
    reset      = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("reset_duty", int'(bus.duty), 0);
    chk("reset_valid", int'(bus.duty_valid), 0);
    chk("reset_perr", int'(bus.period_err), 0);
    chk("reset_stuck", int'(bus.stuck), 0);
    reset = 1'b0;
    hold(1'b0, 10, 0, 0);

    // ideal 64/256: first edge silent
    run_period(64, 256, K_NONE, 0, 0, 0, 0, -1);
    for (int p = 0; p < 4; p++) run_period(64, 256, K_DV, 64, 0, 0, 0, -1);

    // tolerance edges and full-scale clamp (257 high in a 258 period)
    run_period(257, 258, K_DV, 64, 0, 0, 0, -1);
    run_period(100, 254, K_DV, 256, 0, 0, 0, -1);
    run_period(32, 259, K_DV, 100, 0, 0, 0, -1);
    run_period(64, 253, K_PE, 100, 0, 0, 0, -1);
    run_period(64, 256, K_PE, 100, 0, 0, 0, -1);
    run_period(64, 256, K_DV, 64, 0, 0, 0, -1);

    // stuck high: two timeouts at full scale, then stuck low reports 0
    run_period(1100, 1100, K_DV, 64, 0, 2, 256, -1);
    hold(1'b0, 600, 1, 0);
    chk("stuck_level_low", int'(bus.stuck), 1);

    // recovery: armed edge keeps stuck, next edge clears it
    run_period(128, 256, K_NONE, 0, 0, 0, 0, -1);
    chk("stuck_after_armed_edge", int'(bus.stuck), 1);
    run_period(128, 256, K_DV, 128, 0, 0, 0, -1);
    chk("stuck_cleared", int'(bus.stuck), 0);

    // single-tick pulse then low: timeout reports 0
    run_period(1, 600, K_DV, 128, 0, 1, 0, -1);
    chk("stuck_after_low", int'(bus.stuck), 1);

    // mid-period reset discards state
    run_period(64, 256, K_NONE, 0, 0, 0, 0, -1);
    run_period(64, 256, K_DV, 64, 0, 0, 0, -1);
    run_period(64, 256, K_DV, 64, 0, 0, 0, 100);
    run_period(64, 256, K_NONE, 0, 0, 0, 0, -1);
    run_period(64, 256, K_DV, 64, 0, 0, 0, -1);

    // duty sweep
    run_period(1, 256, K_DV, 64, 0, 0, 0, -1);
    run_period(127, 256, K_DV, 1, 0, 0, 0, -1);
    run_period(255, 256, K_DV, 127, 0, 0, 0, -1);
    run_period(64, 256, K_DV, 255, 0, 0, 0, -1);
    push_exp(K_DV, 64, 0);
    hold(1'b1, 10, 0, 0);
    hold(1'b0, 20, 0, 0);

    chk("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
